// File: rtl/boot_fetch_unit.sv
// -----------------------------------------------------------------------------
// boot_fetch_unit
//
// Instruction fetch front-end for the boot ROM. Holds the fetch PC, reads the
// ROM combinationally through rom_addr/rom_inst, and buffers {pc, inst, fault}
// entries in a small prefetch FIFO. The FIFO head is presented to decode over
// a valid/ready handshake. A redirect flushes everything and restarts fetch at
// redirect_pc. A fetch that is misaligned or beyond the ROM produces one
// faulting entry carrying NOP_INST and then halts fetch until a redirect.
//
// Ports:
//   clk             in   1   system clock
//   reset_n         in   1   synchronous active-low reset
//   rom_addr        out  12  byte address to ROM (fetch_pc[11:0])
//   rom_inst        in   32  ROM data, combinational from rom_addr
//   redirect_valid  in   1   flush and restart fetch
//   redirect_pc     in   32  new fetch PC
//   out_valid       out  1   FIFO head is valid
//   out_ready       in   1   decode accepts the head
//   out_pc          out  32  PC of the head entry
//   out_inst        out  32  instruction of the head entry
//   out_fault       out  1   head entry is a fetch fault
//   perf_fetch_cnt  out  32  saturating count of accepted instructions
//                            (present only when FETCH_PERF_CNT_EN is defined)
//
// Build options:
//   FETCH_PERF_CNT_EN  adds the perf_fetch_cnt port and its counter.
//   ASSERT             enables FIFO overflow/underflow assertions.
// -----------------------------------------------------------------------------
module boot_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          ROM_WORDS  = 128,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [11:0] rom_addr,
  input  logic [31:0] rom_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        out_fault
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt
`endif
);

  // Pointer width covers FIFO_DEPTH entries; since the depth is a power of
  // two, natural binary wrap of the pointer gives modulo-depth behaviour.
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  // Count must be able to represent the full value FIFO_DEPTH.
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [CNT_W-1:0] COUNT_FULL = CNT_W'(FIFO_DEPTH);
  // First byte address past the ROM.
  localparam logic [31:0]      ROM_LIMIT  = 32'(ROM_WORDS) << 2;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [31:0]      fetch_pc_reg;
  logic             halted_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;

  logic [31:0]      pc_mem    [FIFO_DEPTH];
  logic [31:0]      inst_mem  [FIFO_DEPTH];
  logic             fault_mem [FIFO_DEPTH];

  // ---------------------------------------------------------------------------
  // Next-state signals
  // ---------------------------------------------------------------------------
  logic [31:0]      fetch_pc_next;
  logic             halted_next;
  logic [PTR_W-1:0] wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_next;
  logic [CNT_W-1:0] count_next;

  logic             pop;
  logic             push;
  logic             fetch_fault;
  logic [31:0]      push_inst;

  // ROM address always tracks the fetch PC, even while halted.
  assign rom_addr = fetch_pc_reg[11:0];

  // Head is valid whenever anything is buffered.
  assign out_valid = (count_reg != '0);
  assign pop       = out_valid && out_ready;

  // Misaligned or out-of-ROM fetches are faults. The compare is on the full
  // 32-bit PC so that high addresses aliasing into rom_addr are still caught.
  assign fetch_fault = (fetch_pc_reg[1:0] != 2'b00) || (fetch_pc_reg >= ROM_LIMIT);

  // A slot is available if the FIFO is not full, or if the head leaves in the
  // same cycle. Redirect takes priority and suppresses the push.
  assign push = !halted_reg && !redirect_valid &&
                ((count_reg < COUNT_FULL) || pop);

  assign push_inst = fetch_fault ? NOP_INST : rom_inst;

  // ---------------------------------------------------------------------------
  // Fetch PC / halt control
  // ---------------------------------------------------------------------------
  always_comb begin
    fetch_pc_next = fetch_pc_reg;
    halted_next   = halted_reg;
    if (redirect_valid) begin
      fetch_pc_next = redirect_pc;
      halted_next   = 1'b0;
    end else if (push) begin
      if (fetch_fault) begin
        // Hold the PC on the faulting address; fetch stays stopped until a
        // redirect supplies a new PC.
        halted_next = 1'b1;
      end else begin
        fetch_pc_next = fetch_pc_reg + 32'd4;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO pointers and occupancy
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (redirect_valid) begin
      // Full flush. A coincident pop is still considered accepted by decode;
      // it simply has nothing left to advance past.
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push) begin
        wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_next = rd_ptr_reg + PTR_W'(1);
      end
      // Simultaneous push and pop leaves occupancy unchanged.
      count_next = count_reg + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fetch_pc_reg <= RESET_PC;
      halted_reg   <= 1'b0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
    end else begin
      fetch_pc_reg <= fetch_pc_next;
      halted_reg   <= halted_next;
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO storage
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        pc_mem[i]    <= '0;
        inst_mem[i]  <= '0;
        fault_mem[i] <= 1'b0;
      end
    end else if (push) begin
      pc_mem[wr_ptr_reg]    <= fetch_pc_reg;
      inst_mem[wr_ptr_reg]  <= push_inst;
      fault_mem[wr_ptr_reg] <= fetch_fault;
    end
  end

  // Outputs come straight from FIFO registers (no path from any input). They
  // are forced to zero while nothing is buffered so stale entries left behind
  // by a flush or reset are never visible.
  assign out_pc    = out_valid ? pc_mem[rd_ptr_reg]    : 32'd0;
  assign out_inst  = out_valid ? inst_mem[rd_ptr_reg]  : 32'd0;
  assign out_fault = out_valid ? fault_mem[rd_ptr_reg] : 1'b0;

  // ---------------------------------------------------------------------------
  // Optional performance counter: accepted instructions, saturating.
  // Redirects do not clear it; only reset does.
  // ---------------------------------------------------------------------------
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_cnt_reg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      perf_cnt_reg <= '0;
    end else if (pop && (perf_cnt_reg != 32'hFFFF_FFFF)) begin
      perf_cnt_reg <= perf_cnt_reg + 32'd1;
    end
  end

  assign perf_fetch_cnt = perf_cnt_reg;
`endif

  // ---------------------------------------------------------------------------
  // Occupancy sanity checks
  // ---------------------------------------------------------------------------
`ifdef ASSERT
  always_ff @(posedge clk) begin
    if (reset_n && !redirect_valid) begin
      assert (!(push && !pop && (count_reg == COUNT_FULL)));
      assert (!(pop && (count_reg == '0)));
      assert (count_reg <= COUNT_FULL);
    end
  end
`endif

endmodule

// File: tb/tb_boot_fetch_unit.sv
module tb_boot_fetch_unit;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int          ROM_WORDS  = 128;
  localparam int          FIFO_DEPTH = 2;
  localparam logic [31:0] NOP_INST   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [11:0] rom_addr;
  logic [31:0] rom_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_fault;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
`endif

  always #5 clk = ~clk;

  // Boot ROM image (covers all 12-bit addresses; entries past the ROM are
  // never delivered because those fetches fault).
  logic [31:0] rom [1024];
  assign rom_inst = rom[rom_addr[11:2]];

  boot_fetch_unit #(
    .RESET_PC  (RESET_PC),
    .ROM_WORDS (ROM_WORDS),
    .FIFO_DEPTH(FIFO_DEPTH),
    .NOP_INST  (NOP_INST)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .rom_addr      (rom_addr),
    .rom_inst      (rom_inst),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_inst      (out_inst),
    .out_fault     (out_fault)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt(perf_fetch_cnt)
`endif
  );

  // ---------------------------------------------------------------------------
  // Reference model: a queue of pending instructions plus a fetch PC.
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fault;
  } entry_t;

  entry_t      mq[$];
  logic [31:0] mpc;
  bit          mhalt;
  logic [31:0] mperf;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic entry_t fetch_one();
    entry_t e;
    e.pc = mpc;
    if (mpc[1:0] != 2'b00 || mpc >= 32'(ROM_WORDS * 4)) begin
      e.inst  = NOP_INST;
      e.fault = 1'b1;
      mhalt   = 1'b1;
    end else begin
      e.inst  = rom[mpc[11:2]];
      e.fault = 1'b0;
      mpc     = mpc + 32'd4;
    end
    return e;
  endfunction

  task automatic model_edge(input bit rst, input bit ready, input bit redir,
                            input logic [31:0] rpc);
    if (!rst) begin
      mq.delete();
      mpc   = RESET_PC;
      mhalt = 1'b0;
      mperf = 32'd0;
    end else begin
      if (mq.size() > 0 && ready) begin
        void'(mq.pop_front());
        if (mperf != 32'hFFFF_FFFF) mperf = mperf + 32'd1;
      end
      if (redir) begin
        mq.delete();
        mpc   = rpc;
        mhalt = 1'b0;
      end else if (!mhalt && mq.size() < FIFO_DEPTH) begin
        mq.push_back(fetch_one());
      end
    end
  endtask

  task automatic check_model();
    chk("model_valid", out_valid, (mq.size() != 0));
    chk("model_rom_addr", rom_addr, {20'd0, mpc[11:0]});
    if (mq.size() != 0) begin
      chk("model_pc", out_pc, mq[0].pc);
      chk("model_inst", out_inst, mq[0].inst);
      chk("model_fault", out_fault, mq[0].fault);
    end
`ifdef FETCH_PERF_CNT_EN
    chk("model_perf", perf_fetch_cnt, mperf);
`endif
  endtask

  // One clock: drive inputs at the falling edge, advance the model at the
  // rising edge, compare at the next falling edge.
  task automatic cycle(input bit rst, input bit ready, input bit redir,
                       input logic [31:0] rpc);
    reset_n        = rst;
    out_ready      = ready;
    redirect_valid = redir;
    redirect_pc    = rpc;
    if (rst && ready && out_valid)
      $display("pop   pc=%08h inst=%08h fault=%0b", out_pc, out_inst, out_fault);
    if (rst && redir)
      $display("redir pc=%08h", rpc);
    if (!rst)
      $display("reset");
    @(posedge clk);
    model_edge(rst, ready, redir, rpc);
    @(negedge clk);
    check_model();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, out_valid, 32'd0);
    chk({tag, "_pc"}, out_pc, 32'd0);
    chk({tag, "_inst"}, out_inst, 32'd0);
    chk({tag, "_fault"}, out_fault, 32'd0);
    chk({tag, "_rom_addr"}, rom_addr, {20'd0, RESET_PC[11:0]});
  endtask

  initial begin
    logic [31:0] rpc;
    reset_n        = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    for (int i = 0; i < 1024; i++) rom[i] = $urandom;
    rom[0]  = 32'h0000_1137;
    rom[1]  = 32'h0001_0113;
    rom[2]  = 32'h0000_0317;
    rom[62] = 32'h2000_0337;   // byte address 0xF8
    mq.delete();
    mpc   = RESET_PC;
    mhalt = 1'b0;
    mperf = 32'd0;
    @(negedge clk);

    // Reset state
    cycle(0, 0, 0, 0);
    cycle(0, 1, 0, 0);
    chk_reset_outputs("reset");

    // Reset release, streaming with out_ready=1
    cycle(1, 1, 0, 0);
    chk("seq0_pc", out_pc, 32'h0);
    chk("seq0_inst", out_inst, 32'h0000_1137);
    chk("seq0_fault", out_fault, 32'd0);
    cycle(1, 1, 0, 0);
    chk("seq1_pc", out_pc, 32'h4);
    chk("seq1_inst", out_inst, 32'h0001_0113);
    cycle(1, 1, 0, 0);
    chk("seq2_pc", out_pc, 32'h8);
    chk("seq2_inst", out_inst, 32'h0000_0317);
    chk("seq2_fault", out_fault, 32'd0);

    // Backpressure
    cycle(0, 0, 0, 0);
    cycle(1, 0, 0, 0);
    chk("bp_first_valid", out_valid, 32'd1);
    for (int i = 0; i < 6; i++) begin
      cycle(1, 0, 0, 0);
      chk("bp_hold_valid", out_valid, 32'd1);
      chk("bp_hold_pc", out_pc, 32'h0);
    end
    chk("bp_rom_addr", rom_addr, 32'h8);
    cycle(1, 1, 0, 0);
    chk("bp_rel1_pc", out_pc, 32'h4);
    cycle(1, 1, 0, 0);
    chk("bp_rel2_pc", out_pc, 32'h8);
    cycle(1, 1, 0, 0);
    chk("bp_rel3_pc", out_pc, 32'hC);

    // Redirect with two entries buffered
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(1, 1, 1, 32'hF8);
    chk("redir_gap_valid", out_valid, 32'd0);
    chk("redir_rom_addr", rom_addr, 32'hF8);
    cycle(1, 1, 0, 0);
    chk("redir_tgt_pc", out_pc, 32'hF8);
    chk("redir_tgt_inst", out_inst, 32'h2000_0337);
    cycle(1, 1, 0, 0);
    chk("redir_next_pc", out_pc, 32'hFC);

    // ROM end fault
    cycle(1, 1, 1, 32'h1F8);
    cycle(1, 1, 0, 0);
    chk("end0_pc", out_pc, 32'h1F8);
    chk("end0_fault", out_fault, 32'd0);
    cycle(1, 1, 0, 0);
    chk("end1_pc", out_pc, 32'h1FC);
    chk("end1_fault", out_fault, 32'd0);
    cycle(1, 1, 0, 0);
    chk("end2_pc", out_pc, 32'h200);
    chk("end2_fault", out_fault, 32'd1);
    chk("end2_inst", out_inst, 32'h0000_0013);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 1, 0, 0);
      chk("end_halt_valid", out_valid, 32'd0);
    end
    chk("end_halt_rom_addr", rom_addr, 32'h200);
    cycle(1, 1, 1, 32'h0);
    cycle(1, 1, 0, 0);
    chk("resume_pc", out_pc, 32'h0);
    chk("resume_fault", out_fault, 32'd0);

    // Misaligned redirect
    cycle(1, 1, 1, 32'h6);
    cycle(1, 1, 0, 0);
    chk("mis_pc", out_pc, 32'h6);
    chk("mis_fault", out_fault, 32'd1);
    chk("mis_inst", out_inst, 32'h0000_0013);
    cycle(1, 1, 0, 0);
    chk("mis_halt_valid", out_valid, 32'd0);
    cycle(1, 1, 0, 0);
    chk("mis_halt_valid2", out_valid, 32'd0);
    chk("mis_rom_addr", rom_addr, 32'h6);

    // Reset mid-stream after 5 pops
    cycle(0, 0, 0, 0);
    cycle(1, 1, 0, 0);
    for (int i = 0; i < 5; i++) cycle(1, 1, 0, 0);
    chk("mid_pc_before", out_pc, 32'h14);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_before_reset", perf_fetch_cnt, 32'd5);
`endif
    cycle(0, 1, 0, 0);
    chk_reset_outputs("midreset");
`ifdef FETCH_PERF_CNT_EN
    chk("perf_after_reset", perf_fetch_cnt, 32'd0);
`endif
    cycle(1, 1, 0, 0);
    chk("restart_pc", out_pc, 32'h0);
    chk("restart_inst", out_inst, 32'h0000_1137);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      bit ready;
      bit redir;
      bit rst;
      ready = ($urandom_range(0, 3) != 0);
      redir = ($urandom_range(0, 19) == 0);
      rst   = ($urandom_range(0, 63) != 0);
      case ($urandom_range(0, 3))
        0: rpc = 32'($urandom_range(0, ROM_WORDS - 1)) << 2;
        1: rpc = 32'h1F0 + (32'($urandom_range(0, 3)) << 2);
        2: rpc = 32'($urandom_range(0, 511));
        default: rpc = $urandom;
      endcase
      cycle(rst, ready, redir, rpc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
